// File: rtl/bf_loop_unit.sv
// Loop-control unit: '[' address stack for backward jumps, nesting-counted
// forward search for skipped loops, sticky stack/nesting fault reporting.
module bf_loop_unit #(
    parameter int unsigned PC_W   = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NEST_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_i,
    input  logic                           is_open_i,
    input  logic                           is_close_i,
    input  logic [PC_W-1:0]                pc_i,
    input  logic                           cell_zero_i,
    input  logic                           flush_i,
    output logic                           searching_o,
    output logic                           jump_o,
    output logic [PC_W-1:0]                jump_target_o,
    output logic [$clog2(DEPTH+1)-1:0]     depth_o,
    output logic                           error_o,
    output logic [1:0]                     err_code_o
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OVER  = 2'd1;
    localparam logic [1:0] ERR_UNDER = 2'd2;
    localparam logic [1:0] ERR_NEST  = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SEARCH = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       depth_d;
    logic [NEST_W-1:0]   nest_q, nest_d;
    logic                searching_d;
    logic                jump_d;
    logic [PC_W-1:0]     target_d;
    logic                error_d;
    logic [1:0]          code_d;
    logic                push_c;
    logic [PC_W-1:0]     stack_q [DEPTH];
    logic [PC_W-1:0]     top_c;

    assign top_c = stack_q[IW'(depth_o - DW'(1))];

    // Next-state, stack control and registered-output values
    always_comb begin
        state_d  = state_q;
        depth_d  = depth_o;
        nest_d   = nest_q;
        jump_d   = 1'b0;
        target_d = '0;
        code_d   = err_code_o;
        push_c   = 1'b0;

        if (flush_i) begin
            state_d = RUN;
            depth_d = '0;
            nest_d  = '0;
            code_d  = ERR_NONE;
        end else if (valid_i && state_q != ERROR) begin
            if (is_open_i && is_close_i) begin
                state_d = ERROR;
                code_d  = ERR_NEST;
            end else begin
                case (state_q)
                    RUN: begin
                        if (is_open_i) begin
                            if (cell_zero_i) begin
                                state_d = SEARCH;
                                nest_d  = NEST_W'(1);
                            end else if (depth_o == DW'(DEPTH)) begin
                                state_d = ERROR;
                                code_d  = ERR_OVER;
                            end else begin
                                push_c  = 1'b1;
                                depth_d = depth_o + DW'(1);
                            end
                        end else if (is_close_i) begin
                            if (depth_o == '0) begin
                                state_d = ERROR;
                                code_d  = ERR_UNDER;
                            end else if (!cell_zero_i) begin
                                jump_d   = 1'b1;
                                target_d = top_c + PC_W'(1);
                            end else begin
                                depth_d = depth_o - DW'(1);
                            end
                        end
                    end
                    SEARCH: begin
                        if (is_open_i) begin
                            if (&nest_q) begin
                                state_d = ERROR;
                                code_d  = ERR_NEST;
                            end else begin
                                nest_d = nest_q + NEST_W'(1);
                            end
                        end else if (is_close_i) begin
                            nest_d = nest_q - NEST_W'(1);
                            if (nest_q == NEST_W'(1)) begin
                                state_d = RUN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        searching_d = (state_d == SEARCH);
        error_d     = (state_d == ERROR);
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            depth_o       <= '0;
            nest_q        <= '0;
            searching_o   <= 1'b0;
            jump_o        <= 1'b0;
            jump_target_o <= '0;
            error_o       <= 1'b0;
            err_code_o    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            depth_o       <= depth_d;
            nest_q        <= nest_d;
            searching_o   <= searching_d;
            jump_o        <= jump_d;
            jump_target_o <= target_d;
            error_o       <= error_d;
            err_code_o    <= code_d;
        end
    end

    // Loop-address storage; entries above depth_o are don't-care
    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            stack_q[IW'(depth_o)] <= pc_i;
        end
    end

endmodule

// File: tb/tb_bf_loop_unit.sv
// Bench for bf_loop_unit: directed scenarios plus random instruction streams
// compared every cycle against a queue-based behavioural model.
module tb_bf_loop_unit;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NEST_W = 2;
    localparam int          MAXNEST = (1 << NEST_W) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_i, is_open_i, is_close_i, cell_zero_i, flush_i;
    logic [PC_W-1:0] pc_i;
    logic            searching_o, jump_o, error_o;
    logic [PC_W-1:0] jump_target_o;
    logic [2:0]      depth_o;
    logic [1:0]      err_code_o;

    int errors = 0;
    int checks = 0;

    // Reference model state: mode 0=run 1=search 2=error
    int          m_mode;
    int          m_nest;
    int          m_code;
    int          m_stack[$];
    logic        e_jump;
    logic [15:0] e_tgt;
    int          search_cycles;

    bf_loop_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .NEST_W(NEST_W)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .is_open_i(is_open_i),
        .is_close_i(is_close_i), .pc_i(pc_i), .cell_zero_i(cell_zero_i),
        .flush_i(flush_i), .searching_o(searching_o), .jump_o(jump_o),
        .jump_target_o(jump_target_o), .depth_o(depth_o), .error_o(error_o),
        .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic v, input logic o, input logic c, input logic [15:0] pc,
                         input logic cz, input logic fl, input logic rs);
        e_jump = 1'b0;
        e_tgt  = 16'h0;
        if (rs || fl) begin
            m_mode = 0; m_nest = 0; m_code = 0; m_stack.delete();
        end else if (v && m_mode != 2) begin
            if (o && c) begin
                m_mode = 2; m_code = 3;
            end else if (m_mode == 0) begin
                if (o) begin
                    if (cz) begin
                        m_mode = 1; m_nest = 1;
                    end else if (m_stack.size() == DEPTH) begin
                        m_mode = 2; m_code = 1;
                    end else begin
                        m_stack.push_back(int'(pc));
                    end
                end else if (c) begin
                    if (m_stack.size() == 0) begin
                        m_mode = 2; m_code = 2;
                    end else if (!cz) begin
                        e_jump = 1'b1;
                        e_tgt  = 16'((m_stack[$] + 1) % 65536);
                    end else begin
                        void'(m_stack.pop_back());
                    end
                end
            end else begin
                if (o) begin
                    if (m_nest == MAXNEST) begin
                        m_mode = 2; m_code = 3;
                    end else begin
                        m_nest++;
                    end
                end else if (c) begin
                    m_nest--;
                    if (m_nest == 0) m_mode = 0;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs
    task automatic step(input logic v, input logic o, input logic c, input logic [15:0] pc,
                        input logic cz, input logic fl, input logic rs);
        valid_i = v; is_open_i = o; is_close_i = c; pc_i = pc;
        cell_zero_i = cz; flush_i = fl; reset = rs;
        @(posedge clk);
        model(v, o, c, pc, cz, fl, rs);
        #1;
        if (searching_o === 1'b1) search_cycles++;
        check_val("searching", 32'(searching_o), 32'(m_mode == 1));
        check_val("jump",      32'(jump_o),      32'(e_jump));
        check_val("target",    32'(jump_target_o), 32'(e_tgt));
        check_val("depth",     32'(depth_o),     32'(m_stack.size()));
        check_val("error",     32'(error_o),     32'(m_mode == 2));
        check_val("err_code",  32'(err_code_o),  32'(m_code));
    endtask

    task automatic ins(input logic o, input logic c, input logic [15:0] pc, input logic cz);
        step(1'b1, o, c, pc, cz, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        m_mode = 0; m_nest = 0; m_code = 0; search_cycles = 0;
        valid_i = 0; is_open_i = 0; is_close_i = 0; pc_i = '0;
        cell_zero_i = 0; flush_i = 0; reset = 1;
        #2;
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Backward jump then loop exit
        ins(1'b1, 1'b0, 16'h0010, 1'b0);
        check_val("push_depth", 32'(depth_o), 32'd1);
        ins(1'b0, 1'b1, 16'h0014, 1'b0);
        check_val("jump_tgt", 32'(jump_target_o), 32'h0011);
        ins(1'b0, 1'b1, 16'h0014, 1'b1);
        check_val("pop_depth", 32'(depth_o), 32'd0);

        // Skip search over a nested loop
        search_cycles = 0;
        ins(1'b1, 1'b0, 16'h0020, 1'b1);
        ins(1'b1, 1'b0, 16'h0021, 1'b0);
        ins(1'b0, 1'b1, 16'h0022, 1'b0);
        ins(1'b0, 1'b1, 16'h0023, 1'b0);
        idle();
        check_val("search_len", 32'(search_cycles), 32'd3);

        // Overflow, inputs ignored while in error, flush recovers
        for (int i = 0; i < 5; i++) ins(1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
        ins(1'b0, 1'b1, 16'h0200, 1'b1);
        ins(1'b1, 1'b1, 16'h0201, 1'b0);
        do_flush();

        // Underflow, then illegal encoding
        ins(1'b0, 1'b1, 16'h0300, 1'b0);
        do_flush();
        ins(1'b1, 1'b1, 16'h0301, 1'b0);
        do_flush();

        // Nest counter overflow
        ins(1'b1, 1'b0, 16'h0400, 1'b1);
        for (int i = 0; i < 3; i++) ins(1'b1, 1'b0, 16'(16'h0401 + i), 1'b0);
        do_flush();

        // Reset mid-search with live stack, then underflow
        for (int i = 0; i < 3; i++) ins(1'b1, 1'b0, 16'(16'h0500 + i), 1'b0);
        ins(1'b1, 1'b0, 16'h0510, 1'b1);
        ins(1'b1, 1'b0, 16'h0511, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        ins(1'b0, 1'b1, 16'h0520, 1'b0);
        do_flush();

        // Wrap of jump target at top of address space
        ins(1'b1, 1'b0, 16'hFFFF, 1'b0);
        ins(1'b0, 1'b1, 16'h0001, 1'b0);
        do_flush();

        // Random instruction streams
        for (int i = 0; i < 2000; i++) begin
            int unsigned r;
            logic v, o, c, cz, fl, rs;
            r  = $urandom_range(0, 99);
            v  = ($urandom_range(0, 99) < 75);
            cz = ($urandom_range(0, 99) < 45);
            o  = 1'b0; c = 1'b0;
            if (r < 48) o = 1'b1;
            else if (r < 96) c = 1'b1;
            else if (r < 98) begin o = 1'b1; c = 1'b1; end
            r  = $urandom_range(0, 99);
            rs = (r < 1);
            fl = (r >= 1 && r < 5) || (m_mode == 2 && r < 25);
            step(v, o, c, 16'($urandom), cz, fl, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
